alu_decode_stage: RTL and testbench

Registered decode stage for the RV64 core: accepts a 32-bit instruction and its PC, decodes it, and presents a registered control bundle to the execute stage. The bundle carries ALU operation, operand-source selects, sign-extended immediate and register indices. The stage sits between fetch and execute. It drives the ALU's `op`, `sub_sra`, `src1`, `src2` and `imm_value` inputs directly. It uses a valid/ready handshake with stall and flush support.

---
 rtl/alu_decode_stage_if.sv | 41 ++++
 rtl/alu_decode_stage.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_decode_stage_if.sv
// Fetch-to-execute bundle for alu_decode_stage: handshake, instruction/PC in,
// decoded control bundle out. The stage itself uses the slave modport.
interface alu_decode_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr_in;
   logic [63:0] pc_in;
   logic        flush_in;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  op_out;
   logic        sub_sra_out;
   logic [1:0]  src1_out;
   logic [1:0]  src2_out;
   logic [63:0] imm_value_out;
   logic [63:0] pc_out;
   logic [4:0]  rs1_out;
   logic [4:0]  rs2_out;
   logic [4:0]  rd_out;
   logic        rd_we_out;
   logic        word_out;
   logic        branch_out;
   logic        jump_out;
   logic        load_out;
   logic        store_out;
   logic        illegal_out;

   modport master (
      output in_valid, instr_in, pc_in, flush_in, out_ready,
      input  in_ready, out_valid, op_out, sub_sra_out, src1_out, src2_out,
             imm_value_out, pc_out, rs1_out, rs2_out, rd_out, rd_we_out,
             word_out, branch_out, jump_out, load_out, store_out, illegal_out
   );

   modport slave (
      input  in_valid, instr_in, pc_in, flush_in, out_ready,
      output in_ready, out_valid, op_out, sub_sra_out, src1_out, src2_out,
             imm_value_out, pc_out, rs1_out, rs2_out, rd_out, rd_we_out,
             word_out, branch_out, jump_out, load_out, store_out, illegal_out
   );
endinterface

// File: rtl/alu_decode_stage.sv
// RV64 decode stage: one-entry registered control bundle with valid/ready, stall and flush.
// Define ALU_DECODE_WORD_OPS_EN to decode OP-IMM-32 / OP-32 as W-ops (word_out=1).
module alu_decode_stage #(
   parameter bit RESET_PC_BYPASS = 1'b0
) (
   input logic               clk,
   input logic               reset,
   alu_decode_stage_if.slave bus
);
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
`ifdef ALU_DECODE_WORD_OPS_EN
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;
`endif

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_XOR  = 3'd1;
   localparam logic [2:0] ALU_OR   = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;
   localparam logic [2:0] ALU_SLL  = 3'd4;
   localparam logic [2:0] ALU_SRL  = 3'd5;
   localparam logic [2:0] ALU_SLT  = 3'd6;
   localparam logic [2:0] ALU_SLTU = 3'd7;

   localparam logic [1:0] SRC1_REG  = 2'd0;
   localparam logic [1:0] SRC1_PC   = 2'd1;
   localparam logic [1:0] SRC1_ZERO = 2'd2;
   localparam logic [1:0] SRC2_REG  = 2'd0;
   localparam logic [1:0] SRC2_IMM  = 2'd1;
   localparam logic [1:0] SRC2_FOUR = 2'd2;

   localparam logic [6:0] F7_ALT = 7'b0100000;

   typedef struct packed {
      logic [2:0]  op;
      logic        sub_sra;
      logic [1:0]  src1;
      logic [1:0]  src2;
      logic [63:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rd_we;
      logic        word;
      logic        branch;
      logic        jump;
      logic        load;
      logic        store;
      logic        illegal;
   } bundle_t;

   function automatic logic [2:0] f3_to_op(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         3'b111:  return ALU_AND;
         default: return ALU_ADD;
      endcase
   endfunction

   logic [31:0] instr_s;
   logic [6:0]  opcode_s;
   logic [2:0]  funct3_s;
   logic [6:0]  funct7_s;
   logic [5:0]  shtop_s;
   logic [4:0]  rs1_s;
   logic [4:0]  rs2_s;
   logic [4:0]  rd_s;
   logic [63:0] imm_i_s;
   logic [63:0] imm_s_s;
   logic [63:0] imm_b_s;
   logic [63:0] imm_u_s;
   logic [63:0] imm_j_s;
   logic        illegal_s;
   logic        in_ready_s;
   logic        load_en_s;
   bundle_t     dec_d;
   bundle_t     bundle_q;
   logic        valid_d;
   logic        valid_q;
   logic [63:0] pc_q;

   assign instr_s  = bus.instr_in;
   assign opcode_s = instr_s[6:0];
   assign funct3_s = instr_s[14:12];
   assign funct7_s = instr_s[31:25];
   assign shtop_s  = instr_s[31:26];
   assign rs1_s    = instr_s[19:15];
   assign rs2_s    = instr_s[24:20];
   assign rd_s     = instr_s[11:7];

   assign imm_i_s = {{52{instr_s[31]}}, instr_s[31:20]};
   assign imm_s_s = {{52{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
   assign imm_b_s = {{51{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
   assign imm_u_s = {{32{instr_s[31]}}, instr_s[31:12], 12'h000};
   assign imm_j_s = {{43{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};

   // Instruction decode into the next control bundle; illegal encodings collapse to a zero bundle.
   always_comb begin
      dec_d     = '0;
      illegal_s = 1'b0;
      case (opcode_s)
         OPC_LUI: begin
            dec_d.src1  = SRC1_ZERO;
            dec_d.src2  = SRC2_IMM;
            dec_d.imm   = imm_u_s;
            dec_d.rd    = rd_s;
            dec_d.rd_we = 1'b1;
         end
         OPC_AUIPC: begin
            dec_d.src1  = SRC1_PC;
            dec_d.src2  = SRC2_IMM;
            dec_d.imm   = imm_u_s;
            dec_d.rd    = rd_s;
            dec_d.rd_we = 1'b1;
         end
         OPC_JAL: begin
            dec_d.src1  = SRC1_PC;
            dec_d.src2  = SRC2_FOUR;
            dec_d.imm   = imm_j_s;
            dec_d.rd    = rd_s;
            dec_d.rd_we = 1'b1;
            dec_d.jump  = 1'b1;
         end
         OPC_JALR: begin
            dec_d.src1  = SRC1_PC;
            dec_d.src2  = SRC2_FOUR;
            dec_d.imm   = imm_i_s;
            dec_d.rs1   = rs1_s;
            dec_d.rd    = rd_s;
            dec_d.rd_we = 1'b1;
            dec_d.jump  = 1'b1;
            illegal_s   = (funct3_s != 3'b000);
         end
         OPC_BRANCH: begin
            dec_d.src1   = SRC1_REG;
            dec_d.src2   = SRC2_REG;
            dec_d.imm    = imm_b_s;
            dec_d.rs1    = rs1_s;
            dec_d.rs2    = rs2_s;
            dec_d.branch = 1'b1;
            case (funct3_s)
               3'b000, 3'b001: begin
                  dec_d.op      = ALU_ADD;
                  dec_d.sub_sra = 1'b1;
               end
               3'b100, 3'b101: dec_d.op = ALU_SLT;
               3'b110, 3'b111: dec_d.op = ALU_SLTU;
               default:        illegal_s = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            dec_d.src1  = SRC1_REG;
            dec_d.src2  = SRC2_IMM;
            dec_d.imm   = imm_i_s;
            dec_d.rs1   = rs1_s;
            dec_d.rd    = rd_s;
            dec_d.rd_we = 1'b1;
            dec_d.load  = 1'b1;
            illegal_s   = (funct3_s == 3'b111);
         end
         OPC_STORE: begin
            dec_d.src1  = SRC1_REG;
            dec_d.src2  = SRC2_IMM;
            dec_d.imm   = imm_s_s;
            dec_d.rs1   = rs1_s;
            dec_d.rs2   = rs2_s;
            dec_d.store = 1'b1;
            illegal_s   = funct3_s[2];
         end
         OPC_OPIMM: begin
            dec_d.op    = f3_to_op(funct3_s);
            dec_d.src1  = SRC1_REG;
            dec_d.src2  = SRC2_IMM;
            dec_d.imm   = imm_i_s;
            dec_d.rs1   = rs1_s;
            dec_d.rd    = rd_s;
            dec_d.rd_we = 1'b1;
            case (funct3_s)
               3'b001:  illegal_s = (shtop_s != 6'b000000);
               3'b101: begin
                  dec_d.sub_sra = (shtop_s == 6'b010000);
                  illegal_s     = (shtop_s != 6'b000000) && (shtop_s != 6'b010000);
               end
               default: illegal_s = 1'b0;
            endcase
         end
         OPC_OP: begin
            dec_d.op      = f3_to_op(funct3_s);
            dec_d.src1    = SRC1_REG;
            dec_d.src2    = SRC2_REG;
            dec_d.rs1     = rs1_s;
            dec_d.rs2     = rs2_s;
            dec_d.rd      = rd_s;
            dec_d.rd_we   = 1'b1;
            dec_d.sub_sra = (funct7_s == F7_ALT);
            illegal_s     = !((funct7_s == 7'b0000000) ||
                              ((funct7_s == F7_ALT) && ((funct3_s == 3'b000) || (funct3_s == 3'b101))));
         end
`ifdef ALU_DECODE_WORD_OPS_EN
         OPC_OPIMM32: begin
            dec_d.op    = f3_to_op(funct3_s);
            dec_d.src1  = SRC1_REG;
            dec_d.src2  = SRC2_IMM;
            dec_d.imm   = imm_i_s;
            dec_d.rs1   = rs1_s;
            dec_d.rd    = rd_s;
            dec_d.rd_we = 1'b1;
            dec_d.word  = 1'b1;
            // W shifts carry a 5-bit shamt, so instr[25] is part of the funct7 check
            case (funct3_s)
               3'b000:  illegal_s = 1'b0;
               3'b001:  illegal_s = (funct7_s != 7'b0000000);
               3'b101: begin
                  dec_d.sub_sra = (funct7_s == F7_ALT);
                  illegal_s     = (funct7_s != 7'b0000000) && (funct7_s != F7_ALT);
               end
               default: illegal_s = 1'b1;
            endcase
         end
         OPC_OP32: begin
            dec_d.op      = f3_to_op(funct3_s);
            dec_d.src1    = SRC1_REG;
            dec_d.src2    = SRC2_REG;
            dec_d.rs1     = rs1_s;
            dec_d.rs2     = rs2_s;
            dec_d.rd      = rd_s;
            dec_d.rd_we   = 1'b1;
            dec_d.word    = 1'b1;
            dec_d.sub_sra = (funct7_s == F7_ALT);
            case (funct3_s)
               3'b000, 3'b101: illegal_s = (funct7_s != 7'b0000000) && (funct7_s != F7_ALT);
               3'b001:         illegal_s = (funct7_s != 7'b0000000);
               default:        illegal_s = 1'b1;
            endcase
         end
`endif
         default: illegal_s = 1'b1;
      endcase

      if (illegal_s) begin
         dec_d         = '0;
         dec_d.illegal = 1'b1;
      end else begin
         dec_d.rd_we = dec_d.rd_we && (dec_d.rd != 5'd0);
      end
   end

   assign in_ready_s = !valid_q || bus.out_ready;
   assign load_en_s  = bus.in_valid && in_ready_s && !bus.flush_in;

   // Valid next-state: flush wins over capture; a consumed bundle without replacement empties the stage.
   always_comb begin
      valid_d = valid_q;
      if (bus.flush_in) begin
         valid_d = 1'b0;
      end else if (load_en_s) begin
         valid_d = 1'b1;
      end else if (bus.out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Pipeline register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= 1'b0;
         bundle_q <= '0;
         pc_q     <= 64'd0;
      end else begin
         valid_q <= valid_d;
         if (load_en_s) begin
            bundle_q <= dec_d;
            pc_q     <= bus.pc_in;
         end
      end
   end

   assign bus.in_ready      = in_ready_s;
   assign bus.out_valid     = valid_q;
   assign bus.op_out        = bundle_q.op;
   assign bus.sub_sra_out   = bundle_q.sub_sra;
   assign bus.src1_out      = bundle_q.src1;
   assign bus.src2_out      = bundle_q.src2;
   assign bus.imm_value_out = bundle_q.imm;
   assign bus.pc_out        = RESET_PC_BYPASS ? bus.pc_in : pc_q;
   assign bus.rs1_out       = bundle_q.rs1;
   assign bus.rs2_out       = bundle_q.rs2;
   assign bus.rd_out        = bundle_q.rd;
   assign bus.rd_we_out     = bundle_q.rd_we;
   assign bus.word_out      = bundle_q.word;
   assign bus.branch_out    = bundle_q.branch;
   assign bus.jump_out      = bundle_q.jump;
   assign bus.load_out      = bundle_q.load;
   assign bus.store_out     = bundle_q.store;
   assign bus.illegal_out   = bundle_q.illegal;
endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed vector table, handshake corner
// sequences, then randomized traffic against an arithmetic decode/handshake reference.
module tb_alu_decode_stage;
   typedef struct packed {
      logic [2:0]  op;
      logic        sub;
      logic [1:0]  src1;
      logic [1:0]  src2;
      logic [63:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rd_we;
      logic        word;
      logic        branch;
      logic        jump;
      logic        load;
      logic        store;
      logic        illegal;
   } bun_t;

   typedef struct {
      logic [31:0] ins;
      bun_t        exp;
   } vec_t;

   localparam int         F3OP [0:7]  = '{0, 4, 6, 7, 1, 5, 2, 3};
   localparam logic [6:0] OPCS [0:10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                          7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B};

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   alu_decode_stage_if bus ();
   alu_decode_stage dut (.clk(clk), .reset(reset), .bus(bus));

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s got=%h exp=%h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bun_t dut_bun();
      bun_t b;
      b.op = bus.op_out;         b.sub = bus.sub_sra_out;
      b.src1 = bus.src1_out;     b.src2 = bus.src2_out;
      b.imm = bus.imm_value_out; b.rs1 = bus.rs1_out;
      b.rs2 = bus.rs2_out;       b.rd = bus.rd_out;
      b.rd_we = bus.rd_we_out;   b.word = bus.word_out;
      b.branch = bus.branch_out; b.jump = bus.jump_out;
      b.load = bus.load_out;     b.store = bus.store_out;
      b.illegal = bus.illegal_out;
      return b;
   endfunction

   // Reference decoder: immediates from signed arithmetic, legality from the instruction rules.
   function automatic bun_t ref_decode(input logic [31:0] ins);
      bun_t       b;
      bit         legal, u1, u2, ud, wide_ok;
      longint     s, imm;
      logic [6:0] opc, f7;
      logic [2:0] f3;
      logic [5:0] top6;
      b = '0; legal = 1'b1; u1 = 1'b0; u2 = 1'b0; ud = 1'b0; imm = 0;
      opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; top6 = ins[31:26];
      s = longint'($signed(ins));
      wide_ok = (f7 == 7'h00) || (f7 == 7'h20);
      case (opc)
         7'h37: begin b.src1 = 2'd2; b.src2 = 2'd1; imm = (s >>> 12) <<< 12; ud = 1'b1; end
         7'h17: begin b.src1 = 2'd1; b.src2 = 2'd1; imm = (s >>> 12) <<< 12; ud = 1'b1; end
         7'h6F: begin
            b.src1 = 2'd1; b.src2 = 2'd2; b.jump = 1'b1; ud = 1'b1;
            imm = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) |
                  (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
         end
         7'h67: begin
            b.src1 = 2'd1; b.src2 = 2'd2; b.jump = 1'b1; imm = s >>> 20;
            u1 = 1'b1; ud = 1'b1; legal = (f3 == 3'd0);
         end
         7'h63: begin
            b.branch = 1'b1; u1 = 1'b1; u2 = 1'b1; legal = (f3 != 3'd2) && (f3 != 3'd3);
            if (f3 < 3'd2) begin b.op = 3'd0; b.sub = 1'b1; end
            else if (f3 < 3'd6) b.op = 3'd6;
            else b.op = 3'd7;
            imm = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11) |
                  (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
         end
         7'h03: begin b.src2 = 2'd1; b.load = 1'b1; imm = s >>> 20; u1 = 1'b1; ud = 1'b1; legal = (f3 != 3'd7); end
         7'h23: begin
            b.src2 = 2'd1; b.store = 1'b1; u1 = 1'b1; u2 = 1'b1; legal = (f3 < 3'd4);
            imm = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
         end
         7'h13: begin
            b.op = 3'(F3OP[f3]); b.src2 = 2'd1; imm = s >>> 20; u1 = 1'b1; ud = 1'b1;
            if (f3 == 3'd1) legal = (top6 == 6'd0);
            if (f3 == 3'd5) begin
               legal = (top6 == 6'd0) || (top6 == 6'd16);
               b.sub = (top6 == 6'd16);
            end
         end
         7'h33: begin
            b.op = 3'(F3OP[f3]); u1 = 1'b1; u2 = 1'b1; ud = 1'b1; b.sub = (f7 == 7'h20);
            legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
         end
`ifdef ALU_DECODE_WORD_OPS_EN
         7'h1B: begin
            b.op = 3'(F3OP[f3]); b.src2 = 2'd1; b.word = 1'b1; imm = s >>> 20; u1 = 1'b1; ud = 1'b1;
            b.sub = (f3 == 3'd5) && (f7 == 7'h20);
            legal = (f3 == 3'd0) || ((f3 == 3'd1) && (f7 == 7'h00)) || ((f3 == 3'd5) && wide_ok);
         end
         7'h3B: begin
            b.op = 3'(F3OP[f3]); b.word = 1'b1; u1 = 1'b1; u2 = 1'b1; ud = 1'b1; b.sub = (f7 == 7'h20);
            legal = (((f3 == 3'd0) || (f3 == 3'd5)) && wide_ok) || ((f3 == 3'd1) && (f7 == 7'h00));
         end
`endif
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         b = '0;
         b.illegal = 1'b1;
      end else begin
         b.imm   = imm;
         b.rs1   = u1 ? ins[19:15] : 5'd0;
         b.rs2   = u2 ? ins[24:20] : 5'd0;
         b.rd    = ud ? ins[11:7] : 5'd0;
         b.rd_we = ud && (ins[11:7] != 5'd0);
      end
      return b;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 9) != 0) begin
         w[6:0] = OPCS[$urandom_range(0, 10)];
         case ($urandom_range(0, 3))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            default: w[31:25] = w[31:25];
         endcase
      end
      return w;
   endfunction

   vec_t        vt [14];
   bun_t        zero_b, ill_b, exp_b, m_b;
   logic [63:0] m_pc;
   bit          m_valid, exp_rdy, iv, fl, ordy;
   logic [31:0] ins;
   logic [63:0] pcv;

   initial begin
      zero_b = '0;
      ill_b = '0;
      ill_b.illegal = 1'b1;
      //          ins            op    sub   s1    s2    imm                    rs1   rs2   rd    we    wd    br    jmp   ld    st    ill
      vt[0]  = '{32'h00500093, '{3'd0, 1'b0, 2'd0, 2'd1, 64'd5,                5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
      vt[1]  = '{32'h402081B3, '{3'd0, 1'b1, 2'd0, 2'd0, 64'd0,                5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
      vt[2]  = '{32'h40335293, '{3'd5, 1'b1, 2'd0, 2'd1, 64'h403,              5'd6, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
      vt[3]  = '{32'hFFFFF0B7, '{3'd0, 1'b0, 2'd2, 2'd1, 64'hFFFFFFFFFFFFF000, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
      vt[4]  = '{32'h00000000, ill_b};
`ifdef ALU_DECODE_WORD_OPS_EN
      vt[5]  = '{32'h0010809B, '{3'd0, 1'b0, 2'd0, 2'd1, 64'd1,                5'd1, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
`else
      vt[5]  = '{32'h0010809B, ill_b};
`endif
      vt[6]  = '{32'h008000EF, '{3'd0, 1'b0, 2'd1, 2'd2, 64'd8,                5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
      vt[7]  = '{32'h0020E463, '{3'd7, 1'b0, 2'd0, 2'd0, 64'd8,                5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
      vt[8]  = '{32'h0020A463, ill_b};
      vt[9]  = '{32'h00000013, '{3'd0, 1'b0, 2'd0, 2'd1, 64'd0,                5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
      vt[10] = '{32'h40009093, ill_b};
      vt[11] = '{32'h0020A223, '{3'd0, 1'b0, 2'd0, 2'd1, 64'd4,                5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}};
      vt[12] = '{32'h12345117, '{3'd0, 1'b0, 2'd1, 2'd1, 64'h12345000,         5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
      vt[13] = '{32'hFFF23193, '{3'd7, 1'b0, 2'd0, 2'd1, 64'hFFFFFFFFFFFFFFFF, 5'd4, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};

      reset = 1'b1;
      bus.in_valid = 1'b0; bus.instr_in = 32'd0; bus.pc_in = 64'd0;
      bus.flush_in = 1'b0; bus.out_ready = 1'b0;
      tick(); tick();
      chk("reset_valid", bus.out_valid, 1'b0);
      chk("reset_bundle", dut_bun(), zero_b);
      chk("reset_pc", bus.pc_out, 64'd0);
      reset = 1'b0;
      tick();
      chk("post_reset_in_ready", bus.in_ready, 1'b1);

      // Directed vectors: one instruction per cycle, execute always ready.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         bus.instr_in = vt[i].ins;
         bus.pc_in    = 64'h8000_0000 + 64'(i * 4);
         bus.in_valid = 1'b1;
         if (i == 0) begin
            #1;
            chk("latency_pre", bus.out_valid, 1'b0);
         end
         tick();
         chk($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
         chk($sformatf("vec%0d_bundle", i), dut_bun(), vt[i].exp);
         chk($sformatf("vec%0d_pc", i), bus.pc_out, 64'h8000_0000 + 64'(i * 4));
      end
      bus.in_valid = 1'b0;
      tick();
      chk("drain_valid", bus.out_valid, 1'b0);

      // Stall with an illegal bundle held, then flush.
      bus.instr_in = 32'h0000_0000; bus.pc_in = 64'h100; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      tick();
      bus.instr_in = 32'h0050_0093; bus.pc_in = 64'h200;
      chk("stall_cap_valid", bus.out_valid, 1'b1);
      chk("stall_cap_bundle", dut_bun(), ill_b);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("stall%0d_valid", c), bus.out_valid, 1'b1);
         chk($sformatf("stall%0d_bundle", c), dut_bun(), ill_b);
         chk($sformatf("stall%0d_pc", c), bus.pc_out, 64'h100);
         chk($sformatf("stall%0d_in_ready", c), bus.in_ready, 1'b0);
      end
      bus.flush_in = 1'b1;
      tick();
      bus.flush_in = 1'b0;
      chk("flush_valid", bus.out_valid, 1'b0);
      // Flush against an acceptable input: nothing captured, in_ready untouched.
      bus.flush_in = 1'b1; bus.in_valid = 1'b1;
      #1;
      chk("flush_in_ready", bus.in_ready, 1'b1);
      tick();
      bus.flush_in = 1'b0; bus.in_valid = 1'b0;
      chk("flush_prio_valid", bus.out_valid, 1'b0);

      // Back-to-back ADDI stream, then reset mid-stream.
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         bus.instr_in = (32'(k) << 20) | 32'h0000_0093;
         bus.pc_in    = 64'h1000 + 64'(k * 4);
         bus.in_valid = 1'b1;
         tick();
         chk($sformatf("stream%0d_valid", k), bus.out_valid, 1'b1);
         chk($sformatf("stream%0d_imm", k), bus.imm_value_out, 64'(k));
         chk($sformatf("stream%0d_pc", k), bus.pc_out, 64'h1000 + 64'(k * 4));
      end
      bus.instr_in = 32'h0090_0093;
      reset = 1'b1;
      tick();
      chk("midreset_valid", bus.out_valid, 1'b0);
      chk("midreset_bundle", dut_bun(), zero_b);
      reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      tick();
      chk("midreset_in_ready", bus.in_ready, 1'b1);
      chk("midreset_idle", bus.out_valid, 1'b0);

      // Randomized traffic against the reference decoder and handshake rules.
      m_valid = 1'b0; m_b = '0; m_pc = 64'd0;
      for (int c = 0; c < 800; c++) begin
         iv   = ($urandom_range(0, 3) != 0);
         fl   = ($urandom_range(0, 15) == 0);
         ordy = ($urandom_range(0, 3) != 0);
         ins  = gen_instr();
         pcv  = {$urandom, $urandom};
         bus.in_valid = iv; bus.flush_in = fl; bus.out_ready = ordy;
         bus.instr_in = ins; bus.pc_in = pcv;
         #1;
         exp_rdy = !m_valid || ordy;
         chk("rnd_in_ready", bus.in_ready, exp_rdy);
         @(posedge clk);
         #1;
         if (fl) m_valid = 1'b0;
         else if (iv && exp_rdy) begin
            m_valid = 1'b1;
            m_b     = ref_decode(ins);
            m_pc    = pcv;
         end else if (ordy) m_valid = 1'b0;
         chk("rnd_valid", bus.out_valid, m_valid);
         if (m_valid) begin
            exp_b = m_b;
            chk($sformatf("rnd_bundle_%h", ins), dut_bun(), exp_b);
            chk("rnd_pc", bus.pc_out, m_pc);
         end
      end
      bus.in_valid = 1'b0; bus.flush_in = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
